// File: rtl/reflet_reset_sequencer.sv
// reflet_reset_sequencer
//   Power-on/reset generator. It synchronises the asynchronous board reset and
//   holds every domain in reset for HOLD_CYCLES. It then releases the CHANNELS
//   active-low domain resets in order 0..CHANNELS-1, STAGGER_CYCLES apart.
//   A software restart (soft_req) or an external hold (ext_hold) re-asserts
//   all domain resets together and re-runs the hold countdown.
//
// Ports
//   clk        in   1         system clock
//   reset      in   1         asynchronous, active-low board reset
//   soft_req   in   1         synchronous pulse: restart the sequence from HOLD
//   ext_hold   in   1         synchronous level: keep all domain resets asserted
//   rst_out_n  out  CHANNELS  active-low domain resets, bit i released i-th
//   busy       out  1         1 while any domain reset is asserted
//   done       out  1         1 once every channel has been released
module reflet_reset_sequencer #(
  parameter int CHANNELS       = 3,
  parameter int HOLD_CYCLES    = 4,
  parameter int STAGGER_CYCLES = 2,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                soft_req,
  input  logic                ext_hold,
  output logic [CHANNELS-1:0] rst_out_n,
  output logic                busy,
  output logic                done
);

  // The state register is the last stage of the deassert synchroniser: it
  // leaves SYNC on the edge where the synchronised reset rises. The explicit
  // chain therefore has one flop fewer than SYNC_STAGES.
  localparam int CHAIN_W = SYNC_STAGES - 1;
  localparam logic [CHAIN_W-1:0] CHAIN_ONE = CHAIN_W'(1);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(CHANNELS + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    S_SYNC,
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_t;

  // Declaration initialisers give the same power-up values as the reset
  // branch, so the sequence still runs on FPGA targets with reset tied high.
  logic [CHAIN_W-1:0]  chain = '0;
  state_t              state = S_SYNC;
  logic [CNT_W-1:0]    cnt   = '0;
  logic [IDX_W-1:0]    idx   = '0;
  logic [CHANNELS-1:0] rel_q = '0;

  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [IDX_W-1:0]    idx_nxt;
  logic [CHANNELS-1:0] rel_nxt;
  logic                sync_ready;

  assign sync_ready = chain[CHAIN_W-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
      state <= S_SYNC;
      cnt   <= '0;
      idx   <= '0;
      rel_q <= '0;
    end else begin
      chain <= (chain << 1) | CHAIN_ONE;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      rel_q <= rel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    rel_nxt   = rel_q;

    unique case (state)
      S_SYNC: begin
        cnt_nxt = '0;
        if (sync_ready) begin
          state_nxt = S_HOLD;
        end
      end

      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          rel_nxt[0] = 1'b1;
          cnt_nxt    = '0;
          idx_nxt    = IDX_W'(1);
          state_nxt  = (CHANNELS == 1) ? S_RUN : S_RELEASE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        if (cnt == STAGGER_LAST) begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (IDX_W'(i) == idx) begin
              rel_nxt[i] = 1'b1;
            end
          end
          cnt_nxt = '0;
          idx_nxt = idx + IDX_W'(1);
          if (idx == IDX_LAST) begin
            state_nxt = S_RUN;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_RUN: begin
        rel_nxt = '1;
      end

      default: begin
        state_nxt = S_SYNC;
        rel_nxt   = '0;
      end
    endcase

    // A restart outside SYNC re-asserts every channel at once. While ext_hold
    // stays high this runs every cycle, which pins the counter at zero.
    if ((state != S_SYNC) && (ext_hold || soft_req)) begin
      state_nxt = S_HOLD;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      rel_nxt   = '0;
    end
  end

  assign rst_out_n = rel_q;
  assign busy      = ~&rel_q;
  assign done      = (state == S_RUN);

endmodule

// File: tb/tb_reflet_reset_sequencer.sv
// Testbench for reflet_reset_sequencer: three instances (default parameters
// with driven reset, default parameters with reset tied high from power-up,
// and a single-channel variant), a timing model for the default instance,
// and literal release-edge expectations.
module tb_reflet_reset_sequencer;

  localparam int CH      = 3;
  localparam int HOLD    = 4;
  localparam int STAGGER = 2;
  localparam int SYNC    = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic softReq = 1'b0;
  logic extHold = 1'b0;
  logic resetTied = 1'b1;
  logic reset6 = 1'b0;
  logic zero = 1'b0;

  logic [CH-1:0] rstOut;
  logic          busy;
  logic          done;
  logic [CH-1:0] rstOutPu;
  logic          busyPu;
  logic          donePu;
  logic [0:0]    rstOut6;
  logic          busy6;
  logic          done6;

  int nChecks = 0;
  int nFails  = 0;

  // Expected rst_out_n at edges 1..10 after reset release (or after power-up).
  logic [CH-1:0] expTable [1:10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                     3'b001, 3'b001, 3'b011, 3'b011, 3'b111};

  always #5 clk = ~clk;

  reflet_reset_sequencer #(
    .CHANNELS(CH), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAGGER), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .soft_req(softReq), .ext_hold(extHold),
    .rst_out_n(rstOut), .busy(busy), .done(done)
  );

  reflet_reset_sequencer #(
    .CHANNELS(CH), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAGGER), .SYNC_STAGES(SYNC)
  ) dutPu (
    .clk(clk), .reset(resetTied), .soft_req(zero), .ext_hold(zero),
    .rst_out_n(rstOutPu), .busy(busyPu), .done(donePu)
  );

  reflet_reset_sequencer #(
    .CHANNELS(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(3), .SYNC_STAGES(3)
  ) dut6 (
    .clk(clk), .reset(reset6), .soft_req(zero), .ext_hold(zero),
    .rst_out_n(rstOut6), .busy(busy6), .done(done6)
  );

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic e);
    @(negedge clk);
    softReq = s;
    extHold = e;
  endtask

  // Model: the number of edges since the hold countdown last started
  // determines which channels are released. Channel i is free once
  // HOLD + i*STAGGER edges have elapsed. Any restart outside the
  // synchronisation phase zeroes that age.
  bit inSync  = 1'b1;
  int syncCnt = 0;
  int holdAge = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      inSync  <= 1'b1;
      syncCnt <= 0;
      holdAge <= 0;
    end else if (inSync) begin
      syncCnt <= syncCnt + 1;
      if (syncCnt + 1 == SYNC) begin
        inSync  <= 1'b0;
        holdAge <= 0;
      end
    end else if (softReq || extHold) begin
      holdAge <= 0;
    end else if (holdAge < 1000) begin
      holdAge <= holdAge + 1;
    end
  end

  function automatic logic [CH-1:0] modelRst();
    logic [CH-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) begin
      r[i] = !inSync && (holdAge >= HOLD + i * STAGGER);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    logic [CH-1:0] e;
    e = modelRst();
    checkOutput("model", {3'b000, rstOut, busy, done}, {3'b000, e, ~&e, &e});
  end

  // Power-up instance with reset tied high: same release edges from edge 1.
  initial begin
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("powerup_edge%0d", e), {5'b0, rstOutPu}, {5'b0, expTable[e]});
    end
    checkOutput("powerup_done", {7'b0, donePu}, 8'd1);
  end

  initial begin
    // Test 1: reset low for three cycles, then the full release sequence.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("seq_edge%0d", e), {5'b0, rstOut}, {5'b0, expTable[e]});
      if (e == 9)  checkOutput("seq_done9", {7'b0, done}, 8'd0);
      if (e == 10) checkOutput("seq_done10", {7'b0, done}, 8'd1);
    end

    // Test 3: soft restart from RUN.
    repeat (2) @(posedge clk);
    applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("soft_drop", {4'b0, rstOut, done}, {4'b0, 3'b000, 1'b0});
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("soft_plus3", {5'b0, rstOut}, 8'b000);
    @(posedge clk);
    #1;
    checkOutput("soft_plus4", {5'b0, rstOut}, 8'b001);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("soft_plus8", {4'b0, rstOut, done}, {4'b0, 3'b111, 1'b1});

    // Test 4: external hold during RELEASE with 011 showing.
    applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    applyStimulus(1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("hold_pre", {5'b0, rstOut}, 8'b011);
    applyStimulus(1'b0, 1'b1);
    for (int h = 1; h <= 5; h++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold_cycle%0d", h), {4'b0, rstOut, busy}, {4'b0, 3'b000, 1'b1});
    end
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold_after3", {5'b0, rstOut}, 8'b000);
    @(posedge clk);
    #1;
    checkOutput("hold_after4", {5'b0, rstOut}, 8'b001);

    // Test 5: asynchronous reset between edges in RELEASE.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("areset_pre", {5'b0, rstOut}, 8'b011);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("areset_async", {3'b0, rstOut, busy, done}, {3'b0, 3'b000, 1'b1, 1'b0});
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("areset_edge6", {5'b0, rstOut}, 8'b001);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("areset_edge10", {4'b0, rstOut, done}, {4'b0, 3'b111, 1'b1});

    // Test 6: single channel, HOLD=1, SYNC_STAGES=3.
    @(negedge clk);
    reset6 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ch1_edge3", {6'b0, rstOut6, done6}, 8'b00);
    @(posedge clk);
    #1;
    checkOutput("ch1_edge4", {6'b0, rstOut6, done6}, 8'b11);
    for (int k = 5; k <= 8; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("ch1_busy%0d", k), {7'b0, busy6}, 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
